// File: rtl/rv_lsu_pkg.sv
// Shared types for the load/store unit: access sizes, the in-flight load
// record and the size-to-byte-mask helper.
package rv_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } t_mem_size;

  // Wide enough for the 8-byte lane offset of a 64-bit data path.
  localparam int OFF_MAX_W = 3;

  typedef struct packed {
    logic [4:0]           rd;
    t_mem_size            size;
    logic                 zext;
    logic [OFF_MAX_W-1:0] offset;
  } t_lsu_entry;

  function automatic logic [7:0] size_to_mask(input t_mem_size size);
    case (size)
      BYTE:    return 8'h01;
      HALF:    return 8'h03;
      WORD:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_fifo.sv
// Generic synchronous FIFO with occupancy count. Pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two.
module rv_lsu_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  entry_t                       push_data,
  output entry_t                       head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read once
  // count says they were written, so reset only needs to clear the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: combinational lane placement towards a variable-latency
// memory, in-order load tracking, registered writeback/exception response.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_we,
  output logic [DATA_W/8-1:0]   mem_req_be,
  output logic [DATA_W-1:0]     mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_misaligned,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  t_mem_size          size;
  logic [OFF_W-1:0]   offset;
  logic               misaligned;
  logic [15:0]        be_wide;
  logic               push;
  logic               pop;
  logic               mis_take;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  t_lsu_entry         push_entry;
  t_lsu_entry         head;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  wmask;
  logic [7:0]         bmask;
  logic               sign;
  logic [DATA_W-1:0]  load_ext;

  assign size   = t_mem_size'(req_size);
  assign offset = req_addr[OFF_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      HALF:    misaligned = offset[0];
      WORD:    misaligned = |offset[1:0];
      DWORD:   misaligned = (DATA_W == 32) || (|offset);
      default: misaligned = 1'b0;
    endcase
  end

  assign be_wide       = {8'h00, size_to_mask(size)} << offset;
  assign mem_req_be    = be_wide[BE_W-1:0];
  assign mem_req_wdata = req_wdata << {offset, 3'b000};
  assign mem_req_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_req_we    = req_we;
  assign mem_req_valid = req_valid & ~misaligned & (req_we | ~full);

  // Misaligned accesses wait for an empty FIFO so their response stays in order.
  always_comb begin
    req_ready = 1'b0;
    if (misaligned)  req_ready = empty;
    else if (req_we) req_ready = mem_req_ready;
    else             req_ready = mem_req_ready & ~full;
  end

  assign push     = req_valid & req_ready & ~req_we & ~misaligned;
  assign pop      = mem_rsp_valid & ~empty;
  assign mis_take = req_valid & misaligned & empty;

  assign push_entry = '{rd: req_rd, size: size, zext: req_unsigned,
                        offset: OFF_MAX_W'(offset)};

  rv_lsu_fifo #(
    .DEPTH   (MAX_OUT),
    .entry_t (t_lsu_entry)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Align the returned word to bit 0, keep the accessed bytes, then extend.
  always_comb begin
    shifted = mem_rsp_data >> {head.offset, 3'b000};
    bmask   = size_to_mask(head.size);
    wmask   = '0;
    for (int i = 0; i < BE_W; i++) wmask[8*i +: 8] = {8{bmask[i]}};
    case (head.size)
      BYTE:    sign = shifted[7];
      HALF:    sign = shifted[15];
      WORD:    sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
    load_ext = (shifted & wmask) | ((sign & ~head.zext) ? ~wmask : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_rd         <= '0;
      rsp_misaligned <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      rsp_valid <= pop | mis_take;
      if (pop) begin
        rsp_data       <= load_ext;
        rsp_rd         <= head.rd;
        rsp_misaligned <= 1'b0;
      end else if (mis_take) begin
        rsp_data       <= '0;
        rsp_rd         <= req_rd;
        rsp_misaligned <= 1'b1;
      end
      if (mem_rsp_valid && empty) proto_err <= 1'b1;
    end
  end

  assign busy = (count != '0) | rsp_valid;

endmodule
